// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch stage. Owns the PC, issues in-order requests to
//            a variable-latency instruction memory, and buffers responses for
//            IF/ID.
// Revision : 1.0 - initial release
// ============================================================================

module if_fetch_stage #(
    parameter int DEPTH = 2,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    output logic          instr_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   c_depth = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] c_full  = CW'(DEPTH);
    localparam logic [CW-1:0] c_one_c = CW'(1);
    localparam logic [AW-1:0] c_one_a = AW'(1);
    localparam logic [PW-1:0] c_one_p = PW'(1);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [DW-1:0] r_instr_mem [DEPTH];
    logic [AW-1:0] r_npc_mem   [DEPTH];

    logic [CW:0]   w_live;
    logic [CW:0]   w_credit;
    logic [CW-1:0] w_out_less;
    logic [AW-1:0] w_npc;
    logic          w_grant;
    logic          w_drop;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    // Credit: live (non-dropped) in-flight responses plus buffered entries
    // must always fit in the FIFO, so a returning response never overflows.
    assign w_live     = {1'b0, r_outstanding} - {1'b0, r_drop_cnt};
    assign w_credit   = w_live + {1'b0, r_count};
    assign imem_req   = !rst && !branch_taken
                        && ({1'b0, r_outstanding} < c_depth)
                        && (w_credit < c_depth);
    assign imem_addr  = r_pc;

    assign w_grant    = imem_req && imem_gnt;
    assign w_drop     = imem_rvalid && (r_drop_cnt != '0);
    assign w_accept   = imem_rvalid && (r_drop_cnt == '0);
    assign w_push     = w_accept && !branch_taken;
    assign w_pop      = (r_count != '0) && !freeze && !branch_taken;
    assign w_npc      = r_resp_pc + c_one_a;
    assign w_out_less = r_outstanding - (imem_rvalid ? c_one_c : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= '0;
            r_resp_pc     <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (branch_taken) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_pc          <= branch_addr;
            r_resp_pc     <= branch_addr;
            r_outstanding <= w_out_less;
            r_drop_cnt    <= w_out_less;
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + c_one_a;
            end
            if (w_accept) begin
                r_resp_pc <= w_npc;
            end
            if (w_grant && !imem_rvalid) begin
                r_outstanding <= r_outstanding + c_one_c;
            end else if (!w_grant && imem_rvalid) begin
                r_outstanding <= r_outstanding - c_one_c;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - c_one_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (branch_taken) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_one_p;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one_p;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_one_c;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_one_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata;
            r_npc_mem[r_wr_ptr]   <= w_npc;
        end
    end

    assign instr_valid = (r_count != '0);
    assign instr_out   = instr_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign pc_out      = instr_valid ? r_npc_mem[r_rd_ptr]   : '0;

    a_push_not_full: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == c_full)));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Randomized scoreboard bench for if_fetch_stage with a behavioural
//            memory and an in-order expected-instruction-stream model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_if_fetch_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0] addr;
        int         due;
    } pend_t;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_addr = '0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr_out;
    logic [7:0]  pc_out;
    logic        instr_valid;

    pend_t      pending[$];
    exp_t       exp_q[$];
    logic [7:0] model_pc = '0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_due = 0;
    int         first_grant = -1;
    int         first_valid = -1;
    bit         branched = 1'b0;

    if_fetch_stage #(.DEPTH(DEPTH), .AW(8), .DW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented instruction must be the next one of the stream
    // started at the last redirect (or reset), in order, none lost or extra.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (branched) begin
                    chk("empty_after_branch", 32'(instr_valid), 32'd0);
                end
                if (!instr_valid) begin
                    chk("idle_outputs", {8'd0, instr_out, pc_out}, 32'd0);
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got instr=%h pc_out=%h, required none (cycle %0d)",
                             instr_out, pc_out, cyc);
                end else begin
                    chk("instr_out", 32'(instr_out), 32'(exp_q[0].instr));
                    chk("pc_out", 32'(pc_out), 32'(exp_q[0].npc));
                    if (first_valid < 0) first_valid = cyc;
                    if (!freeze && !branch_taken) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus + memory model; expected stream entries are pushed on grant.
    task automatic step(input bit fz, input bit br, input logic [7:0] ba,
                        input int gpct, input int llo, input int lhi);
        bit exp_req;
        int due;
        @(negedge clk);
        cyc++;
        freeze       = fz;
        branch_taken = br;
        branch_addr  = ba;
        imem_gnt     = ($urandom_range(99) < gpct);
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = {8'hA0, pending[0].addr};
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        #1;
        exp_req = !br && (pending.size() < DEPTH) && (exp_q.size() < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(model_pc));
        #2;
        if (imem_rvalid) void'(pending.pop_front());
        branched = br;
        if (br) begin
            exp_q.delete();
            model_pc = ba;
        end else if (imem_req && imem_gnt) begin
            due = cyc + int'($urandom_range(lhi, llo));
            if (due < last_due) due = last_due;
            last_due = due;
            pending.push_back('{model_pc, due});
            exp_q.push_back('{{8'hA0, model_pc}, model_pc + 8'd1});
            if (first_grant < 0) first_grant = cyc;
            model_pc = model_pc + 8'd1;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        freeze       = 1'b0;
        branch_taken = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_instr_out", 32'(instr_out), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        exp_q.delete();
        pending.delete();
        model_pc = '0;
        last_due = 0;
        branched = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int drain;
        #2;
        chk("init_imem_req", 32'(imem_req), 32'd0);
        chk("init_imem_addr", 32'(imem_addr), 32'd0);
        chk("init_instr_out", 32'(instr_out), 32'd0);
        chk("init_pc_out", 32'(pc_out), 32'd0);
        chk("init_instr_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with 1-cycle memory.
        repeat (12) step(1'b0, 1'b0, 8'h00, 100, 1, 1);
        chk("first_latency", 32'(first_valid - first_grant), 32'd2);

        // Freeze mid-stream.
        repeat (5) step(1'b1, 1'b0, 8'h00, 100, 1, 1);
        repeat (6) step(1'b0, 1'b0, 8'h00, 100, 1, 1);

        // Redirect with 3-cycle latency responses still in flight.
        repeat (6) step(1'b0, 1'b0, 8'h00, 100, 3, 3);
        step(1'b0, 1'b1, 8'h40, 100, 3, 3);
        repeat (14) step(1'b0, 1'b0, 8'h00, 100, 3, 3);

        // Redirect together with freeze while the buffer is full.
        repeat (4) step(1'b1, 1'b0, 8'h00, 100, 1, 1);
        step(1'b1, 1'b1, 8'h80, 100, 1, 1);
        repeat (8) step(1'b0, 1'b0, 8'h00, 100, 1, 1);

        // Address wrap.
        step(1'b0, 1'b1, 8'hFE, 100, 1, 1);
        repeat (10) step(1'b0, 1'b0, 8'h00, 100, 1, 1);

        // Randomized traffic with a mid-stream asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ba;
            ba = ($urandom_range(3) == 0) ? 8'hFE : 8'($urandom);
            if (i == 700) async_reset();
            step($urandom_range(99) < 30, $urandom_range(99) < 5, ba, 70, 1, 4);
        end

        // Drain: no new grants, everything expected must come out.
        drain = 0;
        while ((exp_q.size() > 0 || pending.size() > 0) && drain < 60) begin
            step(1'b0, 1'b0, 8'h00, 0, 1, 1);
            drain++;
        end
        chk("drain_empty", 32'(exp_q.size() + pending.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
